// File: rtl/program_sequencer.sv
// ----------------------------------------------------------------------------
// program_sequencer
//
// Purpose:
//   Fetches stored instructions in order after an execute press. Each 18-bit
//   word is decoded into opCode/regID1/regID2/immValue and offered to the
//   alu over a valid/ready handshake. Reports busy/done/pc/executedCount
//   for LED and 7-seg status.
//
// Handshake (issue_valid/issue_ready):
//   The decoded fields appear together with issue_valid. They stay stable
//   until the first clock edge where issue_valid && issue_ready are both
//   high. That edge is the single acceptance of the instruction. issue_ready
//   seen without issue_valid is ignored.
//
// Ports:
//   clock, reset        system clock, asynchronous active-high reset
//   executeButton       raw active-low push button
//   instructionsSet     number of valid stored instructions (clamped to DEPTH)
//   mem_rd / mem_addr   read strobe and address to instruction memory
//   mem_data            read data, valid one cycle after mem_rd
//   issue_valid/ready   handshake to the alu
//   opCode..immValue    decoded instruction fields
//   busy, done          run status; done is a one-cycle pulse
//   pc, executedCount   current slot index and accepted-instruction count
//   dbg_state           current FSM state (S_IDLE..S_DONE encoding)
// ----------------------------------------------------------------------------
module program_sequencer #(
    parameter int          DEPTH   = 10,
    parameter int          INSTR_W = 18,
    parameter int          ADDR_W  = 4,
    parameter logic [3:0]  HALT_OP = 4'b1111
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               executeButton,
    input  logic [ADDR_W-1:0]  instructionsSet,
    output logic               mem_rd,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic [INSTR_W-1:0] mem_data,
    output logic               issue_valid,
    input  logic               issue_ready,
    output logic [3:0]         opCode,
    output logic [2:0]         regID1,
    output logic [2:0]         regID2,
    output logic [7:0]         immValue,
    output logic               busy,
    output logic               done,
    output logic [ADDR_W-1:0]  pc,
    output logic [ADDR_W-1:0]  executedCount,
    output logic [2:0]         dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_WAIT  = 3'd2,
        S_ISSUE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);

    state_t              r_state;
    state_t              w_next;

    logic                r_btn_s1;
    logic                r_btn_s2;
    logic                r_btn_hist;
    logic                w_start;

    logic [ADDR_W-1:0]   r_pc;
    logic [ADDR_W-1:0]   r_count;
    logic                r_busy;
    logic [3:0]          r_op;
    logic [2:0]          r_reg1;
    logic [2:0]          r_reg2;
    logic [7:0]          r_imm;

    logic [ADDR_W-1:0]   w_limit;
    logic [ADDR_W-1:0]   w_pc_inc;
    logic                w_mem_rd;
    logic                w_issue;
    logic                w_done;
    logic                w_begin;
    logic                w_load;
    logic                w_accept;

    // Synchronizer flops reset to 1 so a released button never looks like a
    // press; start is the synchronized falling edge (press of active-low).
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_btn_s1   <= 1'b1;
            r_btn_s2   <= 1'b1;
            r_btn_hist <= 1'b1;
        end else begin
            r_btn_s1   <= executeButton;
            r_btn_s2   <= r_btn_s1;
            r_btn_hist <= r_btn_s2;
        end
    end

    assign w_start  = r_btn_hist & ~r_btn_s2;
    assign w_limit  = (instructionsSet > DEPTH_A) ? DEPTH_A : instructionsSet;
    assign w_pc_inc = r_pc + 1'b1;

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and per-state strobes
    always_comb begin
        w_next   = r_state;
        w_mem_rd = 1'b0;
        w_issue  = 1'b0;
        w_done   = 1'b0;
        w_begin  = 1'b0;
        w_load   = 1'b0;
        w_accept = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    if (w_limit != '0) begin
                        w_begin = 1'b1;
                        w_next  = S_FETCH;
                    end else begin
                        w_next  = S_DONE;
                    end
                end
            end
            S_FETCH: begin
                w_mem_rd = 1'b1;
                w_next   = S_WAIT;
            end
            S_WAIT: begin
                // A halt word ends the run without being issued.
                if (mem_data[17:14] == HALT_OP) begin
                    w_next = S_DONE;
                end else begin
                    w_load = 1'b1;
                    w_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_issue = 1'b1;
                if (issue_ready) begin
                    w_accept = 1'b1;
                    w_next   = (w_pc_inc == w_limit) ? S_DONE : S_FETCH;
                end
            end
            S_DONE: begin
                w_done = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Datapath: pc, count, busy and the decoded field registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_pc    <= '0;
            r_count <= '0;
            r_busy  <= 1'b0;
            r_op    <= '0;
            r_reg1  <= '0;
            r_reg2  <= '0;
            r_imm   <= '0;
        end else begin
            if (w_begin) begin
                r_pc    <= '0;
                r_count <= '0;
                r_busy  <= 1'b1;
            end
            if (w_load) begin
                r_op   <= mem_data[17:14];
                r_reg1 <= mem_data[13:11];
                r_reg2 <= mem_data[10:8];
                r_imm  <= mem_data[7:0];
            end
            if (w_accept) begin
                r_count <= r_count + 1'b1;
                // pc only advances when another slot follows, so it stays
                // within 0..DEPTH-1.
                if (w_pc_inc != w_limit) begin
                    r_pc <= w_pc_inc;
                end
            end
            // Leaving DONE clears the fields so they read zero in IDLE.
            if (w_done) begin
                r_busy <= 1'b0;
                r_op   <= '0;
                r_reg1 <= '0;
                r_reg2 <= '0;
                r_imm  <= '0;
            end
        end
    end

    assign mem_rd        = w_mem_rd;
    assign mem_addr      = w_mem_rd ? r_pc : '0;
    assign issue_valid   = w_issue;
    assign opCode        = r_op;
    assign regID1        = r_reg1;
    assign regID2        = r_reg2;
    assign immValue      = r_imm;
    assign busy          = r_busy;
    assign done          = w_done;
    assign pc            = r_pc;
    assign executedCount = r_count;
    assign dbg_state     = r_state;

endmodule

// File: tb/tb_program_sequencer.sv
// ----------------------------------------------------------------------------
// tb_program_sequencer
//
// Directed bench for program_sequencer. Inputs change on the falling edge,
// outputs are sampled on the falling edge, and a small behavioural memory
// answers mem_rd one cycle later. Step counts below are falling edges after
// the button is driven low: +2 start cycle, +3 FETCH, +4 WAIT, +5 ISSUE.
// ----------------------------------------------------------------------------
module tb_program_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        executeButton = 1'b1;
  logic [3:0]  instructionsSet = 4'd0;
  logic        mem_rd;
  logic [3:0]  mem_addr;
  logic [17:0] mem_data = 18'h0;
  logic        issue_valid;
  logic        issue_ready = 1'b0;
  logic [3:0]  opCode;
  logic [2:0]  regID1;
  logic [2:0]  regID2;
  logic [7:0]  immValue;
  logic        busy;
  logic        done;
  logic [3:0]  pc;
  logic [3:0]  executedCount;
  logic [2:0]  dbg_state;

  program_sequencer dut (
    .clock           (clock),
    .reset           (reset),
    .executeButton   (executeButton),
    .instructionsSet (instructionsSet),
    .mem_rd          (mem_rd),
    .mem_addr        (mem_addr),
    .mem_data        (mem_data),
    .issue_valid     (issue_valid),
    .issue_ready     (issue_ready),
    .opCode          (opCode),
    .regID1          (regID1),
    .regID2          (regID2),
    .immValue        (immValue),
    .busy            (busy),
    .done            (done),
    .pc              (pc),
    .executedCount   (executedCount),
    .dbg_state       (dbg_state)
  );

  // clock / reset
  always #5 clock = ~clock;

  // instruction memory model: data valid one cycle after the strobe
  logic [17:0] mem [0:15];
  always @(posedge clock) begin
    if (mem_rd) mem_data <= mem[mem_addr];
  end

  // event monitors
  int         hs_cnt = 0;
  int         rd_cnt = 0;
  int         done_cnt = 0;
  int         valid_cnt = 0;
  logic [3:0] last_addr = 4'd0;
  always @(posedge clock) begin
    if (issue_valid && issue_ready) hs_cnt++;
    if (issue_valid) valid_cnt++;
    if (done) done_cnt++;
    if (mem_rd) begin
      rd_cnt++;
      last_addr = mem_addr;
    end
  end

  int tests = 0;
  int fails = 0;
  int b_hs, b_rd, b_done, b_valid;
  bit seen;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic check_fields(input string tag, input logic [3:0] op, input logic [2:0] r1,
                              input logic [2:0] r2, input logic [7:0] imm);
    check({tag, "_valid"}, issue_valid, 1);
    check({tag, "_op"}, opCode, op);
    check({tag, "_r1"}, regID1, r1);
    check({tag, "_r2"}, regID2, r2);
    check({tag, "_imm"}, immValue, imm);
  endtask

  task automatic snap();
    b_hs    = hs_cnt;
    b_rd    = rd_cnt;
    b_done  = done_cnt;
    b_valid = valid_cnt;
  endtask

  task automatic wait_done(input int max_cycles, output bit got);
    got = 1'b0;
    for (int i = 0; i < max_cycles && !got; i++) begin
      @(negedge clock);
      if (done) got = 1'b1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 18'h0;
    mem[0] = 18'h04A05;
    mem[1] = 18'h09D3C;
    mem[2] = 18'h1C0FF;
    for (int i = 3; i < 10; i++) mem[i] = 18'(i);

    // ---------------- reset state ----------------
    step(3);
    check("rst_mem_rd", mem_rd, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_valid", issue_valid, 0);
    check("rst_fields", {opCode, regID1, regID2, immValue}, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pc", pc, 0);
    check("rst_count", executedCount, 0);
    reset = 1'b0;
    step(2);

    // ---------------- 3-instruction run ----------------
    instructionsSet = 4'd3;
    issue_ready = 1'b1;
    snap();
    executeButton = 1'b0;
    step(2);
    check("a_idle_busy", busy, 0);
    step(1);
    check("a_fetch_rd", mem_rd, 1);
    check("a_fetch_addr", mem_addr, 0);
    check("a_fetch_busy", busy, 1);
    step(1);
    check("a_wait_valid", issue_valid, 0);
    executeButton = 1'b1;
    step(1);
    check_fields("a_i0", 4'h1, 3'd1, 3'd2, 8'h05);
    step(1);
    check("a_f1_valid", issue_valid, 0);
    check("a_f1_pc", pc, 1);
    check("a_f1_addr", mem_addr, 1);
    check("a_f1_count", executedCount, 1);
    step(2);
    check_fields("a_i1", 4'h2, 3'd3, 3'd5, 8'h3C);
    step(3);
    check_fields("a_i2", 4'h7, 3'd0, 3'd0, 8'hFF);
    check("a_i2_pc", pc, 2);
    step(1);
    check("a_done", done, 1);
    check("a_done_count", executedCount, 3);
    step(1);
    check("a_after_done", done, 0);
    check("a_after_busy", busy, 0);
    check("a_idle_fields", {opCode, regID1, regID2, immValue}, 0);
    check("a_after_pc", pc, 2);
    check("a_after_count", executedCount, 3);
    check("a_hs", hs_cnt - b_hs, 3);
    check("a_rd", rd_cnt - b_rd, 3);
    check("a_done_n", done_cnt - b_done, 1);
    step(2);

    // ---------------- backpressure on 2nd instruction ----------------
    snap();
    executeButton = 1'b0;
    step(3);
    executeButton = 1'b1;
    step(2);
    check_fields("b_i0", 4'h1, 3'd1, 3'd2, 8'h05);
    step(2);
    issue_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step(1);
      check_fields("b_hold", 4'h2, 3'd3, 3'd5, 8'h3C);
    end
    check("b_hold_count", executedCount, 1);
    issue_ready = 1'b1;
    step(1);
    check("b_f2_valid", issue_valid, 0);
    check("b_f2_count", executedCount, 2);
    step(2);
    check_fields("b_i2", 4'h7, 3'd0, 3'd0, 8'hFF);
    step(1);
    check("b_done", done, 1);
    step(1);
    check("b_count", executedCount, 3);
    check("b_hs", hs_cnt - b_hs, 3);
    check("b_done_n", done_cnt - b_done, 1);
    step(2);

    // ---------------- reset mid-ISSUE ----------------
    snap();
    executeButton = 1'b0;
    step(3);
    executeButton = 1'b1;
    step(5);
    check_fields("c_pre_i1", 4'h2, 3'd3, 3'd5, 8'h3C);
    check("c_pre_pc", pc, 1);
    reset = 1'b1;
    #1;
    check("c_rst_valid", issue_valid, 0);
    check("c_rst_fields", {opCode, regID1, regID2, immValue}, 0);
    check("c_rst_busy", busy, 0);
    check("c_rst_done", done, 0);
    check("c_rst_pc", pc, 0);
    check("c_rst_count", executedCount, 0);
    check("c_rst_rd", {mem_rd, mem_addr}, 0);
    step(3);
    reset = 1'b0;
    step(3);
    check("c_no_done", done_cnt - b_done, 0);
    executeButton = 1'b0;
    step(3);
    check("c_new_addr", {mem_rd, mem_addr}, 5'h10);
    executeButton = 1'b1;
    step(2);
    check_fields("c_new_i0", 4'h1, 3'd1, 3'd2, 8'h05);
    wait_done(20, seen);
    check("c_done_seen", seen, 1);
    check("c_count", executedCount, 3);
    step(2);

    // ---------------- HALT in slot 1 ----------------
    mem[1] = 18'h3C000;
    instructionsSet = 4'd4;
    snap();
    executeButton = 1'b0;
    step(3);
    executeButton = 1'b1;
    step(2);
    check_fields("d_i0", 4'h1, 3'd1, 3'd2, 8'h05);
    step(1);
    check("d_f1_addr", {mem_rd, mem_addr}, 5'h11);
    step(2);
    check("d_done", done, 1);
    check("d_done_valid", issue_valid, 0);
    step(1);
    check("d_count", executedCount, 1);
    check("d_rd", rd_cnt - b_rd, 2);
    check("d_hs", hs_cnt - b_hs, 1);
    check("d_last_addr", last_addr, 1);
    mem[1] = 18'h09D3C;
    step(2);

    // ---------------- empty program ----------------
    instructionsSet = 4'd0;
    snap();
    executeButton = 1'b0;
    step(3);
    check("e_done", done, 1);
    step(1);
    executeButton = 1'b1;
    check("e_done_low", done, 0);
    step(3);
    check("e_rd", rd_cnt - b_rd, 0);
    check("e_valid", valid_cnt - b_valid, 0);
    check("e_done_n", done_cnt - b_done, 1);

    // ---------------- clamp instructionsSet=15 ----------------
    instructionsSet = 4'd15;
    snap();
    executeButton = 1'b0;
    step(3);
    executeButton = 1'b1;
    wait_done(60, seen);
    check("f_done_seen", seen, 1);
    step(1);
    check("f_hs", hs_cnt - b_hs, 10);
    check("f_rd", rd_cnt - b_rd, 10);
    check("f_last_addr", last_addr, 9);
    check("f_count", executedCount, 10);
    check("f_pc", pc, 9);
    step(2);

    // ---------------- held button and press while busy ----------------
    instructionsSet = 4'd3;
    issue_ready = 1'b0;
    snap();
    executeButton = 1'b0;
    step(50);
    check("g_busy", busy, 1);
    check("g_stalled", issue_valid, 1);
    executeButton = 1'b1;
    step(3);
    executeButton = 1'b0;
    step(5);
    executeButton = 1'b1;
    step(3);
    issue_ready = 1'b1;
    wait_done(40, seen);
    check("g_done_seen", seen, 1);
    step(20);
    check("g_done_n", done_cnt - b_done, 1);
    check("g_hs", hs_cnt - b_hs, 3);
    check("g_rd", rd_cnt - b_rd, 3);
    check("g_busy_end", busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
